// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: EXE/ID forwarding selects, load-use and mul/div stalls,
// branch/jump flush control, a fixed-latency mul/div occupancy FSM and a stall counter.
module hazard_scoreboard #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int SCW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_ID,
  input  logic [AW-1:0] rt_ID,
  input  logic          use_rt_ID,
  input  logic          jump_ID,
  input  logic          md_start_ID,
  input  logic [AW-1:0] md_dst_ID,
  input  logic [AW-1:0] rs_EXE,
  input  logic [AW-1:0] rt_EXE,
  input  logic          load_EXE,
  input  logic [AW-1:0] num_write_EXE,
  input  logic          branch_taken_EXE,
  input  logic          reg_write_MEM,
  input  logic          reg_write_WB,
  input  logic [AW-1:0] num_write_MEM,
  input  logic [AW-1:0] num_write_WB,
  output logic [1:0]    s_a_FWD_EXE,
  output logic [1:0]    s_b_FWD_EXE,
  output logic          s_a_FWD_ID,
  output logic          s_b_FWD_ID,
  output logic          nWrite_PC,
  output logic          nWrite_IF_ID,
  output logic          flush_IF_ID,
  output logic          flush_ID_EXE,
  output logic          md_busy,
  output logic          md_done,
  output logic [AW-1:0] md_dst,
  output logic [SCW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 2);

  md_state_t  state;
  logic [3:0] cnt;

  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic load_stall, md_stall, stall, start_ok;

  always_comb begin
    mem_hit_a = reg_write_MEM && (num_write_MEM != '0) && (num_write_MEM == rs_EXE);
    mem_hit_b = reg_write_MEM && (num_write_MEM != '0) && (num_write_MEM == rt_EXE);
    wb_hit_a  = reg_write_WB  && (num_write_WB  != '0) && (num_write_WB  == rs_EXE);
    wb_hit_b  = reg_write_WB  && (num_write_WB  != '0) && (num_write_WB  == rt_EXE);
    s_a_FWD_EXE = mem_hit_a ? 2'd1 : (wb_hit_a ? 2'd2 : 2'd0);
    s_b_FWD_EXE = mem_hit_b ? 2'd1 : (wb_hit_b ? 2'd2 : 2'd0);
    s_a_FWD_ID  = reg_write_WB && (num_write_WB != '0) && (num_write_WB == rs_ID);
    s_b_FWD_ID  = reg_write_WB && (num_write_WB != '0) && (num_write_WB == rt_ID);
  end

  always_comb begin
    load_stall = load_EXE && (num_write_EXE != '0) &&
                 ((num_write_EXE == rs_ID) || (use_rt_ID && (num_write_EXE == rt_ID)));
    // DONE still stalls readers: the result lands in the register file this cycle
    md_stall   = ((state != IDLE) && (md_dst != '0) &&
                  ((md_dst == rs_ID) || (use_rt_ID && (md_dst == rt_ID)))) ||
                 (md_start_ID && (state == BUSY));
    stall      = load_stall || md_stall;
    start_ok   = md_start_ID && !stall && !branch_taken_EXE && (state != BUSY);

    nWrite_PC    = stall && !branch_taken_EXE;
    nWrite_IF_ID = stall && !branch_taken_EXE;
    flush_ID_EXE = stall || branch_taken_EXE;
    flush_IF_ID  = branch_taken_EXE || (jump_ID && !stall);
    md_busy      = (state != IDLE) && !rst;
    md_done      = (state == DONE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      md_dst    <= '0;
      stall_cnt <= '0;
    end else begin
      if (nWrite_PC && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state  <= BUSY;
            cnt    <= MD_LOAD;
            md_dst <= md_dst_ID;
          end else begin
            state  <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic compared
// cycle by cycle against a timeline-based reference model.
module tb_hazard_scoreboard;
  localparam int AW     = 5;
  localparam int MD_LAT = 4;
  localparam int SCW    = 5;
  localparam int SMAX   = (1 << SCW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_ID, rt_ID, md_dst_ID, rs_EXE, rt_EXE, num_write_EXE;
  logic [AW-1:0] num_write_MEM, num_write_WB;
  logic          use_rt_ID, jump_ID, md_start_ID, load_EXE, branch_taken_EXE;
  logic          reg_write_MEM, reg_write_WB;
  logic [1:0]    s_a_FWD_EXE, s_b_FWD_EXE;
  logic          s_a_FWD_ID, s_b_FWD_ID, nWrite_PC, nWrite_IF_ID;
  logic          flush_IF_ID, flush_ID_EXE, md_busy, md_done;
  logic [AW-1:0] md_dst;
  logic [SCW-1:0] stall_cnt;

  hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .SCW(SCW)) dut (
    .clk(clk), .rst(rst),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rt_ID(use_rt_ID), .jump_ID(jump_ID),
    .md_start_ID(md_start_ID), .md_dst_ID(md_dst_ID),
    .rs_EXE(rs_EXE), .rt_EXE(rt_EXE), .load_EXE(load_EXE),
    .num_write_EXE(num_write_EXE), .branch_taken_EXE(branch_taken_EXE),
    .reg_write_MEM(reg_write_MEM), .reg_write_WB(reg_write_WB),
    .num_write_MEM(num_write_MEM), .num_write_WB(num_write_WB),
    .s_a_FWD_EXE(s_a_FWD_EXE), .s_b_FWD_EXE(s_b_FWD_EXE),
    .s_a_FWD_ID(s_a_FWD_ID), .s_b_FWD_ID(s_b_FWD_ID),
    .nWrite_PC(nWrite_PC), .nWrite_IF_ID(nWrite_IF_ID),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EXE(flush_ID_EXE),
    .md_busy(md_busy), .md_done(md_done), .md_dst(md_dst), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the mul/div op is a start cycle on an absolute timeline.
  int            cyc = 0;
  bit            op_valid = 1'b0;
  int            op_start = 0;
  logic [AW-1:0] m_dst = '0;
  int            m_scnt = 0;
  bit            m_stall, m_nwr, m_busy_raw, m_done_raw;

  function automatic logic [1:0] fwd_exe(input logic [AW-1:0] src);
    if (reg_write_MEM && num_write_MEM != 0 && num_write_MEM == src) return 2'd1;
    if (reg_write_WB && num_write_WB != 0 && num_write_WB == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit reads(input logic [AW-1:0] r);
    return (r != 0) && (r == rs_ID || (use_rt_ID && r == rt_ID));
  endfunction

  task automatic settle();
    bit ld, md;
    @(negedge clk);
    m_busy_raw = op_valid && cyc > op_start && cyc <= op_start + MD_LAT;
    m_done_raw = op_valid && cyc == op_start + MD_LAT;
    ld = load_EXE && reads(num_write_EXE);
    md = (m_busy_raw && reads(m_dst)) || (md_start_ID && m_busy_raw && !m_done_raw);
    m_stall = ld || md;
    m_nwr = m_stall && !branch_taken_EXE;
    check_eq("fwd_a_exe", 32'(s_a_FWD_EXE), 32'(fwd_exe(rs_EXE)));
    check_eq("fwd_b_exe", 32'(s_b_FWD_EXE), 32'(fwd_exe(rt_EXE)));
    check_eq("fwd_a_id", 32'(s_a_FWD_ID), 32'(reg_write_WB && num_write_WB != 0 && num_write_WB == rs_ID));
    check_eq("fwd_b_id", 32'(s_b_FWD_ID), 32'(reg_write_WB && num_write_WB != 0 && num_write_WB == rt_ID));
    check_eq("nwrite_pc", 32'(nWrite_PC), 32'(m_nwr));
    check_eq("nwrite_ifid", 32'(nWrite_IF_ID), 32'(m_nwr));
    check_eq("flush_ifid", 32'(flush_IF_ID), 32'(branch_taken_EXE || (jump_ID && !m_stall)));
    check_eq("flush_idexe", 32'(flush_ID_EXE), 32'(m_stall || branch_taken_EXE));
    check_eq("md_busy", 32'(md_busy), 32'(m_busy_raw && !rst));
    check_eq("md_done", 32'(md_done), 32'(m_done_raw && !rst));
    check_eq("md_dst", 32'(md_dst), 32'(m_dst));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
  endtask

  task automatic advance();
    bit accept;
    accept = md_start_ID && !m_stall && !branch_taken_EXE && (!m_busy_raw || m_done_raw);
    @(posedge clk);
    if (rst) begin
      op_valid = 1'b0;
      m_dst    = '0;
      m_scnt   = 0;
    end else begin
      if (accept) begin
        op_valid = 1'b1;
        op_start = cyc;
        m_dst    = md_dst_ID;
      end
      if (m_nwr && m_scnt < SMAX) m_scnt++;
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic clear_inputs();
    rst = 1'b0; rs_ID = '0; rt_ID = '0; use_rt_ID = 1'b0; jump_ID = 1'b0;
    md_start_ID = 1'b0; md_dst_ID = '0; rs_EXE = '0; rt_EXE = '0; load_EXE = 1'b0;
    num_write_EXE = '0; branch_taken_EXE = 1'b0; reg_write_MEM = 1'b0;
    reg_write_WB = 1'b0; num_write_MEM = '0; num_write_WB = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    #1;
    do_reset();

    // load-use stall on rs, then load to r0 does not stall
    settle();
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_md_busy", 32'(md_busy), 32'd0);
    advance();
    load_EXE = 1'b1; num_write_EXE = 5'd8; rs_ID = 5'd8;
    settle();
    check_eq("ld_nwr_pc", 32'(nWrite_PC), 32'd1);
    check_eq("ld_nwr_ifid", 32'(nWrite_IF_ID), 32'd1);
    check_eq("ld_flush_idexe", 32'(flush_ID_EXE), 32'd1);
    advance();
    clear_inputs();
    settle();
    check_eq("ld_scnt_1", 32'(stall_cnt), 32'd1);
    advance();
    load_EXE = 1'b1; num_write_EXE = 5'd0; rs_ID = 5'd0;
    settle();
    check_eq("ld_r0_nostall", 32'(nWrite_PC), 32'd0);
    advance();

    // EXE forward priority
    clear_inputs();
    reg_write_MEM = 1'b1; num_write_MEM = 5'd5; reg_write_WB = 1'b1; num_write_WB = 5'd5;
    rs_EXE = 5'd5;
    settle();
    check_eq("fwd_mem_prio", 32'(s_a_FWD_EXE), 32'd1);
    advance();
    reg_write_MEM = 1'b0;
    settle();
    check_eq("fwd_wb", 32'(s_a_FWD_EXE), 32'd2);
    advance();

    // mul/div latency and dependent read of reg 9
    clear_inputs();
    md_start_ID = 1'b1; md_dst_ID = 5'd9;
    step();                                  // t=0
    md_start_ID = 1'b0;
    settle(); check_eq("md_busy_t1", 32'(md_busy), 32'd1); advance();
    rs_ID = 5'd9;
    settle(); check_eq("md_stall_t2", 32'(nWrite_PC), 32'd1); advance();
    settle(); check_eq("md_stall_t3", 32'(nWrite_PC), 32'd1);
    check_eq("md_done_t3", 32'(md_done), 32'd0); advance();
    settle(); check_eq("md_done_t4", 32'(md_done), 32'd1);
    check_eq("md_stall_t4", 32'(nWrite_PC), 32'd1); advance();
    settle(); check_eq("md_release_t5", 32'(nWrite_PC), 32'd0);
    check_eq("md_busy_t5", 32'(md_busy), 32'd0); advance();

    // back-to-back start accepted in DONE
    clear_inputs();
    md_start_ID = 1'b1; md_dst_ID = 5'd9;
    step();                                  // t=0
    md_start_ID = 1'b0;
    step();                                  // t=1
    md_start_ID = 1'b1; md_dst_ID = 5'd10;
    settle(); check_eq("b2b_stall_t2", 32'(nWrite_PC), 32'd1); advance();
    settle(); check_eq("b2b_stall_t3", 32'(nWrite_PC), 32'd1); advance();
    settle(); check_eq("b2b_accept_t4", 32'(nWrite_PC), 32'd0);
    check_eq("b2b_done_t4", 32'(md_done), 32'd1); advance();
    md_start_ID = 1'b0;
    for (int i = 5; i < 8; i++) begin
      settle(); check_eq("b2b_nodone", 32'(md_done), 32'd0); advance();
    end
    settle(); check_eq("b2b_done_t8", 32'(md_done), 32'd1);
    check_eq("b2b_dst_t8", 32'(md_dst), 32'd10); advance();

    // branch overrides stall and jump
    clear_inputs();
    branch_taken_EXE = 1'b1; jump_ID = 1'b1; load_EXE = 1'b1; num_write_EXE = 5'd3; rs_ID = 5'd3;
    settle();
    check_eq("br_flush_ifid", 32'(flush_IF_ID), 32'd1);
    check_eq("br_flush_idexe", 32'(flush_ID_EXE), 32'd1);
    check_eq("br_nwr_pc", 32'(nWrite_PC), 32'd0);
    advance();

    // reset aborts a busy op
    clear_inputs();
    md_start_ID = 1'b1; md_dst_ID = 5'd7;
    step();                                  // t=0
    md_start_ID = 1'b0;
    step();                                  // t=1
    rst = 1'b1;
    settle(); check_eq("rst_busy_t2", 32'(md_busy), 32'd0); advance();
    rst = 1'b0;
    for (int i = 3; i < 10; i++) begin
      settle();
      check_eq("abort_busy", 32'(md_busy), 32'd0);
      check_eq("abort_done", 32'(md_done), 32'd0);
      advance();
    end

    // stall counter saturation
    do_reset();
    load_EXE = 1'b1; num_write_EXE = 5'd4; rs_ID = 5'd4;
    for (int i = 0; i < SMAX + 8; i++) step();
    clear_inputs();
    settle(); check_eq("scnt_sat", 32'(stall_cnt), 32'(SMAX)); advance();

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst              = ($urandom_range(0, 199) == 0);
      rs_ID            = AW'($urandom_range(0, 3));
      rt_ID            = AW'($urandom_range(0, 3));
      use_rt_ID        = 1'($urandom);
      jump_ID          = ($urandom_range(0, 7) == 0);
      md_start_ID      = ($urandom_range(0, 2) == 0);
      md_dst_ID        = AW'($urandom_range(0, 3));
      rs_EXE           = AW'($urandom_range(0, 3));
      rt_EXE           = AW'($urandom_range(0, 3));
      load_EXE         = ($urandom_range(0, 3) == 0);
      num_write_EXE    = AW'($urandom_range(0, 3));
      branch_taken_EXE = ($urandom_range(0, 9) == 0);
      reg_write_MEM    = 1'($urandom);
      reg_write_WB     = 1'($urandom);
      num_write_MEM    = AW'($urandom_range(0, 3));
      num_write_WB     = AW'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5: register-index width.
REQ-002 SHALL have parameter MD_LAT, default 4, legal range 2..15: mul/div latency in cycles, from issue to result.
REQ-003 SHALL have parameter SCW, default 16: stall-counter width.
REQ-004 SHALL have these ports, one per line: name, direction, width, meaning.
clk  in  1  the single clock
rst  in  1  reset, synchronous, active-high
rs_ID, rt_ID  in  AW  source registers of the instruction in ID
use_rt_ID  in  1  the ID instruction reads rt
jump_ID  in  1  a J-type instruction is in ID
md_start_ID  in  1  the ID instruction issues a mul/div
md_dst_ID  in  AW  destination register of that mul/div
rs_EXE, rt_EXE  in  AW  source registers of the instruction in EXE
load_EXE  in  1  the EXE instruction is a load
num_write_EXE  in  AW  destination register of the EXE instruction
branch_taken_EXE  in  1  a branch resolved as taken in EXE
reg_write_MEM, reg_write_WB  in  1  write enables of the MEM and WB stages
num_write_MEM, num_write_WB  in  AW  destination registers of the MEM and WB stages
s_a_FWD_EXE, s_b_FWD_EXE  out  2  EXE forward select: 0 none, 1 MEM, 2 WB
s_a_FWD_ID, s_b_FWD_ID  out  1  ID forward select: 0 none, 1 WB
nWrite_PC, nWrite_IF_ID  out  1  PC and IF/ID hold
flush_IF_ID, flush_ID_EXE  out  1  bubble insertion
md_busy  out  1  the mul/div unit is occupied
md_done  out  1  one-cycle pulse: mul/div result is written back this cycle
md_dst  out  AW  destination register of the mul/div in flight
stall_cnt  out  SCW  count of stalled cycles

Function
REQ-005 Forward selects SHALL be combinational.
- Register 0 never forwards.
- For EXE, a MEM match has priority over a WB match.
- ID gets a WB forward when reg_write_WB=1 and num_write_WB equals rs_ID or rt_ID.
REQ-006 load_stall SHALL be 1 when load_EXE=1, num_write_EXE≠0, and num_write_EXE equals rs_ID, or equals rt_ID with use_rt_ID=1.
REQ-007 md_stall SHALL be 1 when the state is BUSY or DONE, md_dst≠0, and md_dst equals rs_ID, or equals rt_ID with use_rt_ID=1.
REQ-008 md_stall SHALL also be 1 when md_start_ID=1 and the state is BUSY.
REQ-009 stall SHALL equal load_stall OR md_stall. stall drives nWrite_PC=1, nWrite_IF_ID=1 and flush_ID_EXE=1.
REQ-010 branch_taken_EXE=1 SHALL override stall:
- flush_IF_ID=1 and flush_ID_EXE=1;
- nWrite_PC=0 and nWrite_IF_ID=0;
- a same-cycle md_start_ID is not accepted.
REQ-011 jump_ID=1 SHALL assert flush_IF_ID only when stall=0. A stalled jump flushes in the cycle its stall clears.
REQ-012 The mul/div FSM SHALL have three states, IDLE, BUSY and DONE, with a counter of 4 bits.
REQ-013 A start SHALL be accepted when md_start_ID=1, stall=0, branch_taken_EXE=0, and the state is IDLE or DONE.
REQ-014 On an accepted start, the next state SHALL be BUSY, cnt SHALL load MD_LAT-2, and md_dst SHALL capture md_dst_ID.
REQ-015 In BUSY, cnt SHALL decrement each cycle. When cnt=0 the next state SHALL be DONE.
REQ-016 DONE SHALL last exactly one cycle. Its next state is BUSY if a start is accepted that cycle, otherwise IDLE.
REQ-017 md_done SHALL be 1 exactly when the state is DONE. md_busy SHALL be 1 when the state is BUSY or DONE.
REQ-018 md_dst SHALL hold its value until the next accepted start.
REQ-019 Latency: a start accepted in cycle t SHALL give md_done=1 in cycle t+MD_LAT.
REQ-020 stall_cnt SHALL increment in every cycle with nWrite_PC=1 and SHALL saturate at all-ones without wrapping.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL reset to: state=IDLE, cnt=0, md_dst=0, stall_cnt=0.
REQ-022 While in reset, md_busy and md_done SHALL be 0. The combinational outputs still follow their inputs.
REQ-023 A reset asserted while the state is BUSY SHALL abort the operation with no md_done pulse.

Verification
REQ-024 Case: load_EXE=1, num_write_EXE=8, rs_ID=8. Required: one cycle of nWrite_PC=nWrite_IF_ID=flush_ID_EXE=1, stall_cnt goes 0 to 1. With num_write_EXE=0 instead, there is no stall.
REQ-025 Case: reg_write_MEM=1, num_write_MEM=5; reg_write_WB=1, num_write_WB=5; rs_EXE=5. Required: s_a_FWD_EXE=1. Dropping the MEM write gives s_a_FWD_EXE=2.
REQ-026 Case: MD_LAT=4, start to reg 9 at t=0. Required:
- md_busy is 1 at t=1..4;
- md_done is 1 only at t=4;
- an ID read of reg 9 at t=2 stalls through t=4 and releases at t=5.
REQ-027 Case: a second md_start_ID at t=2 while BUSY. Required: it stalls until t=4, is accepted at t=4 (DONE), and md_done pulses again at t=8.
REQ-028 Case: branch_taken_EXE=1 in the same cycle as load_stall=1 and jump_ID=1. Required: flush_IF_ID=1, flush_ID_EXE=1, nWrite_PC=0.
REQ-029 Case: rst=1 at t=2 of a BUSY operation. Required: the next cycle shows md_busy=0, and no md_done pulse ever occurs for that operation.
